// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
package sw_debounce_pkg;

  localparam int unsigned SW_WIDTH           = 16;
  localparam int unsigned DEF_SAMPLE_DIV     = 100000;
  localparam int unsigned DEF_STABLE_SAMPLES = 4;

  // Bits needed to count 0..value-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch: 2-FF synchroniser, sample history and committed stable level.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_stable,
  output logic o_chg
);

  logic [1:0]                r_sync;
  logic [STABLE_SAMPLES-2:0] r_hist;
  logic                      r_stable;

  logic [STABLE_SAMPLES-1:0] w_hist_next;
  logic                      w_all_ones;
  logic                      w_all_zeros;
  logic                      w_chg;

  // The newest sample plus the stored ones form the full agreement window.
  always_comb begin
    w_hist_next = {r_hist, r_sync[1]};
    w_all_ones  = &w_hist_next;
    w_all_zeros = ~|w_hist_next;
    w_chg       = i_tick && ((w_all_ones && !r_stable) || (w_all_zeros && r_stable));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_hist   <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (i_tick) r_hist <= w_hist_next[STABLE_SAMPLES-2:0];
      if (w_chg) r_stable <= ~r_stable;
    end
  end

  assign o_stable = r_stable;
  assign o_chg    = w_chg;

endmodule

// File: rtl/switch_debouncer.sv
// Slide-switch front end: sample prescaler, per-bit debouncers, output bytes,
// sticky change mask and level IRQ.
module switch_debouncer
  import sw_debounce_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = DEF_SAMPLE_DIV,
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [SW_WIDTH-1:0] i_sw_raw,
  output logic [7:0]          o_swl,
  output logic [7:0]          o_swh,
  output logic [SW_WIDTH-1:0] o_sw_changed,
  output logic                o_irq,
  input  logic                i_irq_ack,
  output logic                o_sample_tick
);

  localparam int unsigned CntW = clog2(SAMPLE_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_DIV - 1);

  logic [CntW-1:0]     r_cnt;
  logic                r_tick;
  logic [SW_WIDTH-1:0] r_sw;
  logic [SW_WIDTH-1:0] r_mask;
  logic                r_irq;

  logic [SW_WIDTH-1:0] w_stable;
  logic [SW_WIDTH-1:0] w_chg;
  logic [SW_WIDTH-1:0] w_mask_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == CntMax);
      r_cnt  <= (r_cnt == CntMax) ? '0 : r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_debounce_bit (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tick  (r_tick),
      .i_raw   (i_sw_raw[g]),
      .o_stable(w_stable[g]),
      .o_chg   (w_chg[g])
    );
  end

  // ACK clears old bits only; commits in the same cycle survive.
  always_comb begin
    w_mask_next = (i_irq_ack ? '0 : r_mask) | w_chg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw   <= '0;
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_sw   <= w_stable;
      r_mask <= w_mask_next;
      r_irq  <= |w_mask_next;
    end
  end

  assign o_swl         = r_sw[7:0];
  assign o_swh         = r_sw[15:8];
  assign o_sw_changed  = r_mask;
  assign o_irq         = r_irq;
  assign o_sample_tick = r_tick;

endmodule
